fetch_sequencer: RTL and testbench

//   Program-counter controller that sequences instruction fetch from the

---
 rtl/fetch_sequencer.sv | 77 +++++++
 tb/tb_fetch_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for instruction fetch: start/done handshake, stalls,
// sequential increment, relative branches, absolute jumps and a retired-instruction counter.
module fetch_sequencer #(
  parameter int            D          = 12,
  parameter logic [D-1:0]  START_ADDR = '0,
  parameter int            CW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          halt,
  input  logic          branch_en,
  input  logic          abs_jump,
  input  logic [D-1:0]  target,
  input  logic [7:0]    offset,
  output logic [D-1:0]  prog_ctr,
  output logic          fetch_valid,
  output logic          done,
  output logic [CW-1:0] instr_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [D-1:0]  offset_ext;
  logic [D-1:0]  pc_next;
  logic [CW-1:0] count_inc;

  assign offset_ext = D'($signed(offset));

  // Counter sticks at all-ones so long programs never appear to have retired few instructions.
  assign count_inc = (instr_count == {CW{1'b1}}) ? instr_count : instr_count + CW'(1);

  always_comb begin
    pc_next = prog_ctr + D'(1);
    if (branch_en && abs_jump)
      pc_next = target;
    else if (branch_en)
      pc_next = prog_ctr + offset_ext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      prog_ctr    <= START_ADDR;
      instr_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            prog_ctr    <= START_ADDR;
            instr_count <= '0;
          end
        end
        RUN: begin
          // A stall freezes everything, including a pending halt or branch.
          if (!stall) begin
            instr_count <= count_inc;
            if (halt)
              state <= DONE;
            else
              prog_ctr <= pc_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fetch_valid = (state == RUN) && !stall;
  assign done        = (state == DONE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a behavioural model.
module tb_fetch_sequencer;

  localparam int D    = 12;
  localparam int CW   = 4;
  localparam int MASK = (1 << D) - 1;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, stall, halt, branch_en, abs_jump;
  logic [D-1:0]  target;
  logic [7:0]    offset;
  logic [D-1:0]  prog_ctr;
  logic          fetch_valid, done;
  logic [CW-1:0] instr_count;

  int vectors    = 0;
  int miscompares = 0;
  bit cmp_en     = 1'b0;

  // Behavioural model of the program-counter controller.
  bit running;
  bit finished;
  int m_pc;
  int m_cnt;

  fetch_sequencer #(.D(D), .START_ADDR('0), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .branch_en(branch_en), .abs_jump(abs_jump), .target(target), .offset(offset),
    .prog_ctr(prog_ctr), .fetch_valid(fetch_valid), .done(done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      running  <= 1'b0;
      finished <= 1'b0;
      m_pc     <= 0;
      m_cnt    <= 0;
    end else if (!running) begin
      if (start) begin
        running  <= 1'b1;
        finished <= 1'b0;
        m_pc     <= 0;
        m_cnt    <= 0;
      end
    end else if (!stall) begin
      m_cnt <= (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
      if (halt) begin
        running  <= 1'b0;
        finished <= 1'b1;
      end else if (branch_en && abs_jump)
        m_pc <= int'(target);
      else if (branch_en)
        m_pc <= (m_pc + int'($signed(offset))) & MASK;
      else
        m_pc <= (m_pc + 1) & MASK;
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("model.prog_ctr", int'(prog_ctr), m_pc);
      check_output("model.fetch_valid", int'(fetch_valid), int'(running && !stall));
      check_output("model.done", int'(done), int'(finished));
      check_output("model.instr_count", int'(instr_count), m_cnt);
    end
  end

  task automatic set_inputs(input bit st, input bit sl, input bit h, input bit be,
                            input bit aj, input logic [D-1:0] tg, input logic [7:0] of);
    start = st; stall = sl; halt = h; branch_en = be; abs_jump = aj; target = tg; offset = of;
  endtask

  task automatic cycle(input bit st, input bit sl, input bit h, input bit be,
                       input bit aj, input logic [D-1:0] tg, input logic [7:0] of);
    set_inputs(st, sl, h, be, aj, tg, of);
    @(posedge clk);
    #1;
  endtask

  task automatic plain(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, '0, '0);
  endtask

  task automatic check_state(input string tag, input int pc, input int fv, input int dn, input int cnt);
    check_output({tag, ".prog_ctr"}, int'(prog_ctr), pc);
    check_output({tag, ".fetch_valid"}, int'(fetch_valid), fv);
    check_output({tag, ".done"}, int'(done), dn);
    check_output({tag, ".instr_count"}, int'(instr_count), cnt);
  endtask

  initial begin
    reset = 1'b1;
    set_inputs(0, 0, 0, 0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    check_state("reset", 0, 0, 0, 0);

    // Start, four plain fetches, then halt.
    cycle(1, 0, 0, 0, 0, '0, '0);
    check_state("start", 0, 1, 0, 0);
    plain(4);
    check_state("plain4", 4, 1, 0, 4);
    cycle(0, 0, 1, 0, 0, '0, '0);
    check_state("halt", 4, 0, 1, 5);

    // Restart from DONE, then saturate the 4-bit counter.
    cycle(1, 0, 0, 0, 0, '0, '0);
    check_state("restart", 0, 1, 0, 0);
    plain(20);
    check_state("saturate", 20, 1, 0, 15);

    // Relative branches, including a wrap below zero.
    cycle(0, 0, 0, 1, 1, 12'h010, '0);
    check_output("jump010", int'(prog_ctr), 'h010);
    cycle(0, 0, 0, 1, 0, '0, 8'hFD);
    check_output("rel_back3", int'(prog_ctr), 'h00D);
    cycle(0, 0, 0, 1, 1, 12'h002, '0);
    cycle(0, 0, 0, 1, 0, '0, 8'hFD);
    check_output("rel_wrap", int'(prog_ctr), 'hFFF);
    cycle(0, 0, 0, 1, 0, '0, 8'h7F);
    check_output("rel_fwd", int'(prog_ctr), 'h07E);

    // Absolute jump to the top address, then sequential wrap.
    cycle(0, 0, 0, 1, 1, 12'hFFF, '0);
    check_output("jumpFFF", int'(prog_ctr), 'hFFF);
    plain(1);
    check_output("inc_wrap", int'(prog_ctr), 'h000);

    // Stall overrides halt and branch; dropping stall lets halt through.
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 1, 1, 1, 12'h123, '0);
      check_state("stall", 0, 0, 0, 15);
    end
    cycle(0, 0, 1, 1, 1, 12'h123, '0);
    check_state("stall_halt", 0, 0, 1, 15);

    // Asynchronous reset in the middle of a run.
    cycle(1, 0, 0, 0, 0, '0, '0);
    plain(5);
    check_output("pre_reset_pc", int'(prog_ctr), 5);
    #1 reset = 1'b1;
    #1 check_state("async_reset", 0, 0, 0, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Randomized traffic, with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        #2 reset = 1'b0;
      end
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 4) == 0, 1'($urandom), D'($urandom), 8'($urandom));
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
